// File: rtl/data_mem_responder.sv
// Data-memory responder for the CPU load/store port: one outstanding request,
// a fixed number of wait states, then a single-cycle response pulse.
module data_mem_responder #(
    parameter int DW          = 32,
    parameter int ADDR_WIDTH  = 12,
    parameter int WAIT_CYCLES = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid_i,
    output logic          req_ready_o,
    input  logic          req_we_i,
    input  logic          req_byte_i,
    input  logic [DW-1:0] req_addr_i,
    input  logic [DW-1:0] req_wdata_i,
    output logic          resp_valid_o,
    output logic [DW-1:0] resp_rdata_o,
    output logic          resp_err_o,
    output logic [1:0]    dbg_state_o
);
    localparam int         DEPTH   = 2 ** (ADDR_WIDTH - 2);
    localparam logic [3:0] LP_WAIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [3:0]      r_cnt;
    logic            r_we;
    logic            r_byte;
    logic [DW-1:0]   r_addr;
    logic [DW-1:0]   r_wdata;
    logic [DW-1:0]   r_rdata;
    logic            r_err;
    logic [DW-1:0]   r_mem [DEPTH];

    logic            w_we;
    logic            w_byte;
    logic [DW-1:0]   w_addr;
    logic [DW-1:0]   w_wdata;
    logic            w_err;
    logic            w_enter_resp;
    logic            w_mem_we;
    logic [ADDR_WIDTH-3:0] w_idx;
    logic [4:0]      w_lane_sh;
    logic [DW-1:0]   w_word;
    logic [DW-1:0]   w_load;
    logic [DW-1:0]   w_lane_mask;
    logic [DW-1:0]   w_byte_wr;

    // Handshake: a request transfers on a rising edge where req_valid_i && req_ready_o.
    // Ready is high only in IDLE, so at most one request is ever outstanding.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (req_valid_i) begin
                    w_next = (LP_WAIT == 4'd0) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_cnt == 4'd1) begin
                    w_next = S_RESP;
                end
            end
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready_o  = (r_state == S_IDLE);
        resp_valid_o = (r_state == S_RESP);
        resp_err_o   = (r_state == S_RESP) && r_err;
        resp_rdata_o = r_rdata;
        dbg_state_o  = r_state;
    end

    // With no wait states the access happens on the acceptance edge itself,
    // before the capture registers are loaded, so take the live inputs then.
    always_comb begin
        w_we    = (r_state == S_IDLE) ? req_we_i    : r_we;
        w_byte  = (r_state == S_IDLE) ? req_byte_i  : r_byte;
        w_addr  = (r_state == S_IDLE) ? req_addr_i  : r_addr;
        w_wdata = (r_state == S_IDLE) ? req_wdata_i : r_wdata;
    end

    always_comb begin
        w_err        = (|w_addr[DW-1:ADDR_WIDTH]) || (!w_byte && (|w_addr[1:0]));
        w_idx        = w_addr[ADDR_WIDTH-1:2];
        w_lane_sh    = {w_addr[1:0], 3'b000};
        w_word       = r_mem[w_idx];
        w_load       = w_byte ? ((w_word >> w_lane_sh) & DW'(8'hFF)) : w_word;
        w_lane_mask  = DW'(8'hFF) << w_lane_sh;
        w_byte_wr    = (w_word & ~w_lane_mask) | (DW'(w_wdata[7:0]) << w_lane_sh);
        w_enter_resp = (w_next == S_RESP) && (r_state != S_RESP);
        w_mem_we     = w_enter_resp && w_we && !w_err && rst;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt   <= 4'd0;
            r_we    <= 1'b0;
            r_byte  <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            if (r_state == S_IDLE && req_valid_i) begin
                r_we    <= req_we_i;
                r_byte  <= req_byte_i;
                r_addr  <= req_addr_i;
                r_wdata <= req_wdata_i;
                r_cnt   <= LP_WAIT;
            end else if (r_state == S_WAIT) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_enter_resp) begin
                r_err   <= w_err;
                r_rdata <= (w_err || w_we) ? '0 : w_load;
            end
        end
    end

    // Storage is deliberately not reset; byte stores merge into the current word.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_idx] <= w_byte ? w_byte_wr : w_wdata;
        end
    end
endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: a cycle-level reference model checks every
// cycle, directed requests pin literal results, then randomized traffic.
module tb_data_mem_responder;
    localparam int W = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;

    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic        req_byte = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        ready;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [1:0]  dbg;

    logic        z_valid = 1'b0;
    logic        z_we = 1'b0;
    logic        z_byte = 1'b0;
    logic [31:0] z_addr = '0;
    logic [31:0] z_wdata = '0;
    logic        z_ready;
    logic        z_resp_valid;
    logic [31:0] z_resp_rdata;
    logic        z_resp_err;
    logic [1:0]  z_dbg;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    data_mem_responder #(.DW(32), .ADDR_WIDTH(12), .WAIT_CYCLES(W)) dut (
        .clk(clk), .rst(rst_n), .req_valid_i(req_valid), .req_ready_o(ready),
        .req_we_i(req_we), .req_byte_i(req_byte), .req_addr_i(req_addr),
        .req_wdata_i(req_wdata), .resp_valid_o(resp_valid), .resp_rdata_o(resp_rdata),
        .resp_err_o(resp_err), .dbg_state_o(dbg)
    );

    data_mem_responder #(.DW(32), .ADDR_WIDTH(12), .WAIT_CYCLES(0)) dut_w0 (
        .clk(clk), .rst(rst_n), .req_valid_i(z_valid), .req_ready_o(z_ready),
        .req_we_i(z_we), .req_byte_i(z_byte), .req_addr_i(z_addr),
        .req_wdata_i(z_wdata), .resp_valid_o(z_resp_valid), .resp_rdata_o(z_resp_rdata),
        .resp_err_o(z_resp_err), .dbg_state_o(z_dbg)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Reference model: flat word array, little-endian lanes, plain arithmetic.
    bit [31:0]   m_mem [1024];
    bit          m_pend = 1'b0;
    int          m_due = 0;
    int          m_free = 0;
    logic [31:0] m_hold = '0;
    bit          m_we;
    bit          m_by;
    logic [31:0] m_a;
    logic [31:0] m_wd;
    bit          m_valid;
    bit          m_err;
    logic [31:0] m_rd;

    task automatic model_access(input bit we, input bit by, input logic [31:0] a,
                                input logic [31:0] wd, output bit err, output logic [31:0] rd);
        int idx;
        int lane;
        err  = (a >= 32'h1000) || (!by && (a % 4) != 0);
        rd   = '0;
        idx  = int'(a / 4) % 1024;
        lane = int'(a % 4);
        if (!err) begin
            if (we) begin
                if (by) m_mem[idx] = (m_mem[idx] & ~(32'hFF << (8 * lane))) | ({24'b0, wd[7:0]} << (8 * lane));
                else    m_mem[idx] = wd;
            end else begin
                rd = by ? ((m_mem[idx] >> (8 * lane)) & 32'hFF) : m_mem[idx];
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_pend = 1'b0;
                m_free = 0;
                m_hold = '0;
                check("rst_ready", 32'(ready), 32'd1);
                check("rst_valid", 32'(resp_valid), 32'd0);
                check("rst_err", 32'(resp_err), 32'd0);
                check("rst_rdata", resp_rdata, 32'd0);
            end else begin
                m_valid = m_pend && (cyc == m_due);
                m_err = 1'b0;
                if (m_valid) begin
                    model_access(m_we, m_by, m_a, m_wd, m_err, m_rd);
                    m_hold = m_rd;
                    m_pend = 1'b0;
                end
                check("ready", 32'(ready), 32'(cyc >= m_free));
                check("resp_valid", 32'(resp_valid), 32'(m_valid));
                check("resp_err", 32'(resp_err), 32'(m_err));
                check("resp_rdata", resp_rdata, m_hold);
                if (cyc >= m_free && req_valid) begin
                    m_we = req_we; m_by = req_byte; m_a = req_addr; m_wd = req_wdata;
                    m_pend = 1'b1;
                    m_due  = cyc + W + 1;
                    m_free = cyc + W + 2;
                end
            end
        end
    end

    task automatic accept_only(input bit we, input bit by, input logic [31:0] a,
                               input logic [31:0] wd, output int acc);
        req_valid = 1'b1; req_we = we; req_byte = by; req_addr = a; req_wdata = wd;
        acc = -1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (ready) begin
                acc = cyc;
                break;
            end
        end
        if (acc < 0) check("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_we = 1'($urandom); req_byte = 1'($urandom);
        req_addr = $urandom; req_wdata = $urandom;
    endtask

    task automatic do_req(input bit we, input bit by, input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output bit err, output int lat);
        int acc;
        bit got = 1'b0;
        accept_only(we, by, a, wd, acc);
        rd = '0; err = 1'b0; lat = -1;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (resp_valid) begin
                got = 1'b1; rd = resp_rdata; err = resp_err; lat = cyc - acc;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic z_req(input bit we, input logic [31:0] a, input logic [31:0] wd,
                         output logic [31:0] rd, output bit err, output int lat);
        int acc = -1;
        bit got = 1'b0;
        z_valid = 1'b1; z_we = we; z_byte = 1'b0; z_addr = a; z_wdata = wd;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (z_ready) begin
                acc = cyc;
                break;
            end
        end
        @(posedge clk);
        #1;
        z_valid = 1'b0;
        rd = '0; err = 1'b0; lat = -1;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (z_resp_valid) begin
                got = 1'b1; rd = z_resp_rdata; err = z_resp_err; lat = (acc < 0) ? -1 : cyc - acc;
            end
        end
        @(posedge clk);
        #1;
    endtask

    logic [31:0] haddr [4] = '{32'h100, 32'h104, 32'h108, 32'h10C};

    initial begin
        logic [31:0] rd;
        bit          err;
        int          lat;
        int          acc;
        int          n_acc;
        int          n_resp;
        int          extra;
        int          rc [4];
        bit          acc_now;
        bit          r_we;
        bit          r_by;
        logic [31:0] r_a;

        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 1024; i++) begin
            accept_only(1'b1, 1'b0, 32'(i * 4), (i == 16) ? 32'h0BADF00D : $urandom, acc);
        end

        do_req(1'b1, 1'b0, 32'h100, 32'hDEADBEEF, rd, err, lat);
        check("st_word_lat", 32'(lat), 32'd3);
        check("st_word_err", 32'(err), 32'd0);
        check("st_word_rdata", rd, 32'd0);
        do_req(1'b0, 1'b0, 32'h100, 32'h0, rd, err, lat);
        check("ld_word_lat", 32'(lat), 32'd3);
        check("ld_word_rdata", rd, 32'hDEADBEEF);
        check("ld_word_err", 32'(err), 32'd0);

        do_req(1'b1, 1'b1, 32'h102, 32'hFFFFFF5A, rd, err, lat);
        do_req(1'b0, 1'b0, 32'h100, 32'h0, rd, err, lat);
        check("byte_merge", rd, 32'hDE5ABEEF);
        do_req(1'b0, 1'b1, 32'h103, 32'h0, rd, err, lat);
        check("ld_byte_lane3", rd, 32'h000000DE);

        do_req(1'b0, 1'b0, 32'h102, 32'h0, rd, err, lat);
        check("misalign_err", 32'(err), 32'd1);
        check("misalign_rdata", rd, 32'd0);
        do_req(1'b1, 1'b0, 32'h1001, 32'h11111111, rd, err, lat);
        check("range_err", 32'(err), 32'd1);
        check("range_rdata", rd, 32'd0);
        do_req(1'b0, 1'b0, 32'h100, 32'h0, rd, err, lat);
        check("no_write_on_err", rd, 32'hDE5ABEEF);

        n_acc = 0; n_resp = 0;
        req_valid = 1'b1; req_we = 1'b0; req_byte = 1'b0; req_addr = haddr[0];
        for (int i = 0; i < 60 && n_resp < 4; i++) begin
            @(negedge clk);
            if (resp_valid) begin
                rc[n_resp] = cyc;
                n_resp++;
            end
            acc_now = ready && req_valid;
            @(posedge clk);
            #1;
            if (acc_now) begin
                n_acc++;
                if (n_acc < 4) req_addr = haddr[n_acc];
                else req_valid = 1'b0;
            end
        end
        check("held_valid_resps", 32'(n_resp), 32'd4);
        for (int k = 1; k < 4; k++) check("held_valid_spacing", 32'(rc[k] - rc[k-1]), 32'd4);
        extra = 0;
        repeat (8) begin
            @(negedge clk);
            if (resp_valid) extra++;
        end
        @(posedge clk);
        #1;
        check("held_valid_no_extra", 32'(extra), 32'd0);

        accept_only(1'b1, 1'b0, 32'h40, 32'h12345678, acc);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        extra = 0;
        repeat (6) begin
            @(negedge clk);
            if (resp_valid) extra++;
        end
        @(posedge clk);
        #1;
        check("rst_drop_no_resp", 32'(extra), 32'd0);
        do_req(1'b0, 1'b0, 32'h40, 32'h0, rd, err, lat);
        check("rst_drop_no_store", rd, 32'h0BADF00D);

        for (int i = 0; i < 300; i++) begin
            r_we = 1'($urandom_range(0, 1));
            r_by = 1'($urandom_range(0, 1));
            r_a  = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 4095));
            if (!r_by && $urandom_range(0, 3) != 0) r_a = r_a & 32'hFFFFFFFC;
            accept_only(r_we, r_by, r_a, $urandom, acc);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
        repeat (6) @(posedge clk);
        #1;

        z_req(1'b1, 32'h3FC, 32'hCAFEF00D, rd, err, lat);
        check("w0_store_lat", 32'(lat), 32'd1);
        check("w0_store_err", 32'(err), 32'd0);
        z_req(1'b0, 32'h3FC, 32'h0, rd, err, lat);
        check("w0_load_lat", 32'(lat), 32'd1);
        check("w0_load_rdata", rd, 32'hCAFEF00D);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
